// File: rtl/syscall_unit_pkg.sv
// Shared service codes and FSM state type for the syscall unit.
package syscall_unit_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [31:0] SYS_PRINT_HEX = 32'd34;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRINT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  function automatic logic is_print_code(input logic [31:0] code);
    return (code == SYS_PRINT_INT) || (code == SYS_PRINT_HEX);
  endfunction

endpackage

// File: rtl/syscall_unit_sat_counter.sv
// Saturating up-counter used for the completed-syscall count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// Execute-stage syscall handler: print handshake, program exit, stall control.
// Define SYSCALL_COUNT_EN to build the saturating sys_count counter.
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               is_syscall,
  input  logic               inst_valid,
  input  logic [31:0]        v0,
  input  logic [31:0]        a0,
  input  logic               disp_ready,
  output logic               disp_valid,
  output logic [31:0]        disp_data,
  output logic               stall,
  output logic               halted,
  output logic [COUNT_W-1:0] sys_count
);

  state_t state;
  logic   trigger;
  logic   blocking_code;

  assign trigger       = is_syscall && inst_valid && (state == IDLE);
  assign blocking_code = is_print_code(v0) || (v0 == SYS_EXIT);

  // Gated by rst so the pipeline is never frozen while the unit is held in reset.
  assign stall = !rst && ((state != IDLE) || (trigger && blocking_code));

  assign disp_valid = (state == PRINT);
  assign halted     = (state == HALTED);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      disp_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trigger) begin
            if (v0 == SYS_EXIT) begin
              state <= HALTED;
            end else if (is_print_code(v0)) begin
              state     <= PRINT;
              disp_data <= a0;
            end
          end
        end
        PRINT: begin
          if (disp_ready) state <= IDLE;
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSCALL_COUNT_EN
  logic count_inc;

  // Halt and unknown codes finish on the trigger edge; prints finish on the handshake.
  assign count_inc = (trigger && !is_print_code(v0)) || ((state == PRINT) && disp_ready);

  sat_counter #(.W(COUNT_W)) u_sat_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (count_inc),
    .count (sys_count)
  );
`else
  assign sys_count = '0;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: directed scenarios plus random traffic
// against a behavioural model. Honours SYSCALL_COUNT_EN like the design.
module tb_syscall_unit;

`ifdef SYSCALL_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          is_syscall;
  logic          inst_valid;
  logic [31:0]   v0;
  logic [31:0]   a0;
  logic          disp_ready;
  logic          disp_valid;
  logic [31:0]   disp_data;
  logic          stall;
  logic          halted;
  logic [CW-1:0] sys_count;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model: what the unit is doing, the latched value, completed count.
  typedef enum int { M_IDLE, M_PRINT, M_HALT } mode_t;
  mode_t       m_mode;
  logic [31:0] m_data;
  int          m_cnt;

  syscall_unit #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .is_syscall (is_syscall),
    .inst_valid (inst_valid),
    .v0         (v0),
    .a0         (a0),
    .disp_ready (disp_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .stall      (stall),
    .halted     (halted),
    .sys_count  (sys_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  function automatic int exp_count();
    return COUNT_EN ? m_cnt : 0;
  endfunction

  function automatic bit blocking(input logic [31:0] code);
    return code == 32'd1 || code == 32'd34 || code == 32'd10;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic model_complete();
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic model_compare();
    bit exp_stall;
    if (rst) exp_stall = 0;
    else exp_stall = (m_mode != M_IDLE) ||
                     (is_syscall && inst_valid && blocking(v0));
    check("m_stall",      32'(stall),      32'(exp_stall));
    check("m_disp_valid", 32'(disp_valid), 32'(!rst && m_mode == M_PRINT));
    check("m_halted",     32'(halted),     32'(!rst && m_mode == M_HALT));
    check("m_disp_data",  disp_data,       rst ? 32'd0 : m_data);
    check("m_sys_count",  32'(sys_count),  rst ? 32'd0 : 32'(exp_count()));
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: if (is_syscall && inst_valid) begin
        if (v0 == 32'd10) begin
          m_mode = M_HALT;
          model_complete();
        end else if (v0 == 32'd1 || v0 == 32'd34) begin
          m_mode = M_PRINT;
          m_data = a0;
        end else begin
          model_complete();
        end
      end
      M_PRINT: if (disp_ready) begin
        m_mode = M_IDLE;
        model_complete();
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic s, input logic iv, input logic [31:0] v, input logic [31:0] a,
                       input logic rdy);
    is_syscall = s;
    inst_valid = iv;
    v0         = v;
    a0         = a;
    disp_ready = rdy;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called after settle(): check against model, apply the edge to the model, wait a cycle.
  task automatic advance();
    model_compare();
    model_step();
    @(negedge clk);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    settle();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #2;
    check("rst_stall",      32'(stall),      32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_halted",     32'(halted),     32'd0);
    check("rst_sys_count",  32'(sys_count),  32'd0);
    check("rst_disp_data",  disp_data,       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Print with a slow sink; the held instruction must not re-trigger.
    begin
      int stall_cycles = 0;
      drive(1, 1, 32'd34, 32'hDEAD_BEEF, 0);
      settle();
      check("print_trig_stall", 32'(stall), 32'd1);
      stall_cycles += int'(stall);
      advance();
      for (int i = 0; i < 3; i++) begin
        drive(1, 1, 32'd34, 32'h1234_5678, 0);
        settle();
        check("print_wait_valid", 32'(disp_valid), 32'd1);
        check("print_wait_data",  disp_data,       32'hDEAD_BEEF);
        stall_cycles += int'(stall);
        advance();
      end
      drive(1, 1, 32'd34, 32'h1234_5678, 1);
      settle();
      check("print_hs_valid", 32'(disp_valid), 32'd1);
      stall_cycles += int'(stall);
      advance();
      drive(0, 1, 0, 0, 0);
      settle();
      check("print_done_valid", 32'(disp_valid), 32'd0);
      check("print_done_stall", 32'(stall),      32'd0);
      check("print_stall_cycles", 32'(stall_cycles), 32'd5);
      check("print_count", 32'(sys_count), COUNT_EN ? 32'd1 : 32'd0);
      advance();
    end

    // Exit, then a later print request is ignored.
    sync_reset();
    drive(1, 1, 32'd10, 0, 0);
    settle();
    check("exit_trig_stall", 32'(stall), 32'd1);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'd1, 32'h55, 1);
      settle();
      check("exit_halted",     32'(halted),     32'd1);
      check("exit_stall",      32'(stall),      32'd1);
      check("exit_disp_valid", 32'(disp_valid), 32'd0);
      check("exit_count", 32'(sys_count), COUNT_EN ? 32'd1 : 32'd0);
      advance();
    end

    // Unknown code, bubble, and a code that only matches exit in the low bits.
    sync_reset();
    drive(1, 1, 32'd5, 32'd7, 1);
    settle();
    check("unk_stall", 32'(stall), 32'd0);
    advance();
    drive(1, 0, 32'd10, 0, 1);
    settle();
    check("unk_valid",    32'(disp_valid), 32'd0);
    check("unk_count",    32'(sys_count),  COUNT_EN ? 32'd1 : 32'd0);
    check("bubble_stall", 32'(stall),      32'd0);
    advance();
    drive(1, 1, 32'h1000_000A, 0, 0);
    settle();
    check("bubble_halted", 32'(halted), 32'd0);
    check("wide_stall",    32'(stall),  32'd0);
    advance();
    drive(0, 1, 0, 0, 0);
    settle();
    check("wide_halted", 32'(halted),    32'd0);
    check("wide_count",  32'(sys_count), COUNT_EN ? 32'd2 : 32'd0);
    advance();

    // Saturation: five ignored-code syscalls.
    sync_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'd5, 32'(i), 0);
      settle();
      advance();
    end
    drive(0, 0, 0, 0, 0);
    settle();
    check("sat_count", 32'(sys_count), COUNT_EN ? 32'd3 : 32'd0);
    advance();

    // Asynchronous reset in the middle of a PRINT wait.
    drive(1, 1, 32'd1, 32'hCAFE_0001, 0);
    settle();
    advance();
    drive(1, 1, 32'd10, 0, 0);
    settle();
    check("arst_pre_valid", 32'(disp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid",  32'(disp_valid), 32'd0);
    check("arst_stall",  32'(stall),      32'd0);
    check("arst_data",   disp_data,       32'd0);
    check("arst_halted", 32'(halted),     32'd0);
    check("arst_count",  32'(sys_count),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 0, 1);
    settle();
    check("arst_after_valid", 32'(disp_valid), 32'd0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] code;
      case ($urandom_range(0, 6))
        0:       code = 32'd1;
        1:       code = 32'd34;
        2:       code = 32'd10;
        3:       code = 32'd5;
        4:       code = 32'h1000_000A;
        5:       code = 32'h0000_0022 | (32'(1) << $urandom_range(8, 31));
        default: code = $urandom;
      endcase
      rst = ($urandom_range(0, 99) < 3);
      drive(($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 8), code, $urandom,
            ($urandom_range(0, 9) < 5));
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
